// File: rtl/config_stream_loader_pkg.sv
// Shared definitions for the PE tile configuration bus.
// Holds the section codes, the address field positions and the loader
// state encoding. The tile decoders import the same package, so the
// section codes and field positions are defined only here.
package config_stream_loader_pkg;

  // Section codes carried in config_addr[31:16]. Section 0 matches no tile.
  localparam logic [15:0] CONFIG_SB  = 16'd7;
  localparam logic [15:0] CONFIG_CB0 = 16'd6;
  localparam logic [15:0] CONFIG_CB1 = 16'd5;
  localparam logic [15:0] CONFIG_CLB = 16'd4;

  // Field positions inside config_addr.
  localparam int SECTION_MSB = 31;
  localparam int SECTION_LSB = 16;
  localparam int TILE_MSB    = 15;
  localparam int TILE_LSB    = 0;

  typedef struct packed {
    logic [15:0] section;
    logic [15:0] tile_id;
  } cfg_addr_t;

  // Loader states.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_DRIVE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  function automatic logic [31:0] cfg_addr(input logic [15:0] section,
                                           input logic [15:0] tile_id);
    cfg_addr_t a;
    a.section = section;
    a.tile_id = tile_id;
    return a;
  endfunction

endpackage

// File: rtl/config_stream_loader_hold.sv
// config_hold_counter: down-counter timing how long a write stays on the bus.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   load       : reload with HOLD_CYCLES-1 (write just launched)
//   dec        : count down by one
//   zero       : counter is at 0 (last hold cycle)
module config_hold_counter #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  // HOLD_CYCLES==1 still needs a 1-bit counter to stay legal.
  localparam int W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (load) cnt <= W'(HOLD_CYCLES - 1);
    else if (dec)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/config_stream_loader.sv
// config_stream_loader: configuration master for the PE tile array.
// Reads a word stream (count, then count address/data pairs) and issues
// each pair as one write on config_addr/config_data, held for HOLD_CYCLES.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   start          : begin a load (honoured only in IDLE or DONE)
//   in_valid/in_data/in_ready : word stream handshake
//   config_addr/config_data   : shared config bus ({section, tile_id}, data)
//   busy, done     : load in progress / last load completed (sticky)
//   writes_issued  : writes completed in the current or last load
module config_stream_loader
  import config_stream_loader_pkg::*;
#(
  parameter int          HOLD_CYCLES = 1,
  parameter int          COUNT_W     = 16,
  parameter logic [31:0] IDLE_ADDR   = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [31:0]        in_data,
  output logic               in_ready,
  output logic [31:0]        config_addr,
  output logic [31:0]        config_data,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] writes_issued
);

  logic [2:0]         state;
  logic [COUNT_W-1:0] remaining;
  logic [31:0]        addr_reg;
  logic               xfer;
  logic               hold_zero;

  // Stream is only accepted while collecting count/address/data words.
  always_comb begin
    in_ready = (state == ST_COUNT) || (state == ST_ADDR) || (state == ST_DATA);
  end

  assign xfer = in_valid && in_ready;

  config_hold_counter #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk   (clk),
    .reset (reset),
    .load  ((state == ST_DATA) && xfer),
    .dec   ((state == ST_DRIVE) && !hold_zero),
    .zero  (hold_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      config_addr   <= IDLE_ADDR;
      config_data   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      writes_issued <= '0;
      remaining     <= '0;
      addr_reg      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state         <= ST_COUNT;
            busy          <= 1'b1;
            done          <= 1'b0;
            writes_issued <= '0;
          end
        end
        ST_COUNT: begin
          if (xfer) begin
            remaining <= in_data[COUNT_W-1:0];
            state     <= (in_data[COUNT_W-1:0] == '0) ? ST_DONE : ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (xfer) begin
            addr_reg <= in_data;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (xfer) begin
            config_addr <= addr_reg;
            config_data <= in_data;
            state       <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          // Last hold cycle: release the bus and retire the write.
          if (hold_zero) begin
            config_addr   <= IDLE_ADDR;
            config_data   <= '0;
            writes_issued <= writes_issued + 1'b1;
            remaining     <= remaining - 1'b1;
            state         <= (remaining == COUNT_W'(1)) ? ST_DONE : ST_ADDR;
          end
        end
        ST_DONE: begin
          if (start) begin
            state         <= ST_COUNT;
            busy          <= 1'b1;
            done          <= 1'b0;
            writes_issued <= '0;
          end else begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_stream_loader.sv
// Bench for config_stream_loader: two instances (HOLD_CYCLES 1 and 4) share
// one stream driver selected by sel. Expected writes are queued when the
// data word is driven and compared when the write leaves the bus.
module tb_config_stream_loader;
  import config_stream_loader_pkg::*;

  localparam logic [31:0] IDLE = 32'h0000_0000;

  logic        clk = 0, reset = 1, start = 0, in_valid = 0, sel = 0;
  logic [31:0] in_data = '0;

  logic        rdy_a, busy_a, done_a, rdy_b, busy_b, done_b;
  logic [31:0] addr_a, data_a, addr_b, data_b;
  logic [15:0] wi_a, wi_b;

  always #5 clk = ~clk;

  config_stream_loader #(.HOLD_CYCLES(1)) u_a (
    .clk(clk), .reset(reset), .start(start && !sel), .in_valid(in_valid && !sel),
    .in_data(in_data), .in_ready(rdy_a), .config_addr(addr_a), .config_data(data_a),
    .busy(busy_a), .done(done_a), .writes_issued(wi_a));

  config_stream_loader #(.HOLD_CYCLES(4)) u_b (
    .clk(clk), .reset(reset), .start(start && sel), .in_valid(in_valid && sel),
    .in_data(in_data), .in_ready(rdy_b), .config_addr(addr_b), .config_data(data_b),
    .busy(busy_b), .done(done_b), .writes_issued(wi_b));

  wire        rdy  = sel ? rdy_b  : rdy_a;
  wire        done = sel ? done_b : done_a;
  wire        busy = sel ? busy_b : busy_a;
  wire [15:0] wi   = sel ? wi_b   : wi_a;
  wire [31:0] addr = sel ? addr_b : addr_a;
  wire [31:0] data = sel ? data_b : data_a;

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // ---- bus monitors / scoreboards ----
  logic [63:0] qa[$], qb[$];
  bit          mon_en = 1;
  bit          act_a = 0, act_b = 0;
  int          cnt_a = 0, cnt_b = 0, nw_a = 0, nw_b = 0;
  logic [63:0] cur_a, cur_b, exp_a, exp_b;

  always @(negedge clk) begin
    if (!mon_en || reset) act_a = 0;
    else if (addr_a != IDLE) begin
      check("rdy_drive_a", rdy_a, 0);
      if (!act_a) begin act_a = 1; cnt_a = 1; cur_a = {addr_a, data_a}; end
      else begin cnt_a++; check("bus_stable_a", {addr_a, data_a}, cur_a); end
    end else if (act_a) begin
      act_a = 0; nw_a++;
      check("hold_a", cnt_a, 1);
      check("data_idle_a", data_a, 0);
      exp_a = (qa.size() != 0) ? qa.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
      check("write_a", cur_a, exp_a);
    end
  end

  always @(negedge clk) begin
    if (!mon_en || reset) act_b = 0;
    else if (addr_b != IDLE) begin
      check("rdy_drive_b", rdy_b, 0);
      if (!act_b) begin act_b = 1; cnt_b = 1; cur_b = {addr_b, data_b}; end
      else begin cnt_b++; check("bus_stable_b", {addr_b, data_b}, cur_b); end
    end else if (act_b) begin
      act_b = 0; nw_b++;
      check("hold_b", cnt_b, 4);
      check("data_idle_b", data_b, 0);
      exp_b = (qb.size() != 0) ? qb.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
      check("write_b", cur_b, exp_b);
    end
  end

  // PE tile 3, section CB0, as a decoder would see the bus.
  logic [2:0] tile3_cb0 = '0;
  always @(posedge clk)
    if (addr_b == cfg_addr(CONFIG_CB0, 16'd3)) tile3_cb0 <= data_b[2:0];

  // ---- stream driver (call at a negedge; returns at a negedge) ----
  task automatic put(input logic [31:0] w, input bit gap);
    if (gap) begin in_valid = 0; @(negedge clk); end
    in_valid = 1; in_data = w;
    for (int i = 0; !rdy; i++) begin
      if (i > 50) begin check("rdy_timeout", rdy, 1); break; end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic pulse_start();
    start = 1; @(negedge clk); start = 0;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
    if (sel) qb.push_back({a, d}); else qa.push_back({a, d});
  endtask

  logic [31:0] wa[4], wd[4];

  task automatic run_load(input bit gap, input int n, input logic [31:0] cw);
    pulse_start();
    put(cw, gap);
    for (int i = 0; i < n; i++) begin
      put(wa[i], gap);
      push_exp(wa[i], wd[i]);
      put(wd[i], gap);
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300 && !done; i++) @(negedge clk);
    check(tag, done, 1);
  endtask

  int base;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_addr_a", addr_a, IDLE);   check("rst_data_a", data_a, 0);
    check("rst_rdy_a", rdy_a, 0);        check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);      check("rst_wi_a", wi_a, 0);
    check("rst_addr_b", addr_b, IDLE);   check("rst_done_b", done_b, 0);
    reset = 0;
    @(negedge clk);

    // Count 1 (upper count-word bits ignored), HOLD 1, continuous valid.
    sel = 0;
    wa[0] = 32'h0007_0003; wd[0] = 32'h0000_0005;
    run_load(0, 1, 32'hABCD_0001);
    wait_done("t1_done");
    check("t1_wi", wi_a, 1); check("t1_nw", nw_a, 1); check("t1_busy", busy_a, 0);

    // Count 0: done one cycle after the count transfer, no bus activity.
    pulse_start();
    check("t2_busy", busy_a, 1);
    put(32'h0, 0);
    check("t2_done_lat", done_a, 0);
    @(negedge clk);
    check("t2_done", done_a, 1); check("t2_wi", wi_a, 0); check("t2_nw", nw_a, 1);

    // Count 3 with in_valid toggling.
    base = nw_a;
    wa[0] = cfg_addr(CONFIG_SB, 16'd3);  wd[0] = 32'h1111_0001;
    wa[1] = cfg_addr(CONFIG_CLB, 16'd8); wd[1] = 32'h2222_0002;
    wa[2] = cfg_addr(CONFIG_CB1, 16'd1); wd[2] = 32'h3333_0003;
    run_load(1, 3, 32'd3);
    wait_done("t3_done");
    check("t3_wi", wi_a, 3); check("t3_nw", nw_a - base, 3);

    // HOLD 4, count 2, tile 3 CB0 captures data[2:0].
    sel = 1;
    wa[0] = cfg_addr(CONFIG_CB0, 16'd3); wd[0] = 32'hFFFF_FFF5;
    wa[1] = cfg_addr(CONFIG_CB0, 16'd4); wd[1] = 32'h0000_0002;
    run_load(0, 2, 32'd2);
    wait_done("t4_done");
    check("t4_wi", wi_b, 2); check("t4_nw", nw_b, 2); check("t4_tile", tile3_cb0, 3'd5);

    // Reset during DRIVE of the 2nd of 3 writes.
    wa[0] = cfg_addr(CONFIG_SB, 16'd9);  wd[0] = 32'hA0;
    wa[1] = cfg_addr(CONFIG_CB1, 16'd9); wd[1] = 32'hA1;
    pulse_start();
    put(32'd3, 0);
    put(wa[0], 0); push_exp(wa[0], wd[0]); put(wd[0], 0);
    put(wa[1], 0);
    mon_en = 0;
    put(wd[1], 0);
    check("t5_mid_addr", addr_b, wa[1]);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("t5_addr", addr_b, IDLE); check("t5_data", data_b, 0);
    check("t5_busy", busy_b, 0);    check("t5_done", done_b, 0);
    check("t5_wi", wi_b, 0);
    reset = 0; mon_en = 1;
    @(negedge clk);
    base = nw_b;
    wa[0] = cfg_addr(CONFIG_CLB, 16'd2); wd[0] = 32'h77;
    run_load(0, 1, 32'd1);
    wait_done("t5_fresh_done");
    check("t5_fresh_wi", wi_b, 1); check("t5_fresh_nw", nw_b - base, 1);

    // start while busy is ignored; start in DONE relaunches once.
    sel = 0;
    base = nw_a;
    wa[0] = cfg_addr(CONFIG_CB0, 16'd5); wd[0] = 32'h55;
    wa[1] = cfg_addr(CONFIG_SB, 16'd6);  wd[1] = 32'h66;
    pulse_start();
    put(32'd2, 0);
    put(wa[0], 0);
    pulse_start();
    push_exp(wa[0], wd[0]); put(wd[0], 0);
    put(wa[1], 0); push_exp(wa[1], wd[1]); put(wd[1], 0);
    wait_done("t6_done");
    check("t6_wi", wi_a, 2); check("t6_nw", nw_a - base, 2);
    start = 1;
    repeat (3) @(negedge clk);
    start = 0;
    check("t6_re_busy", busy_a, 1); check("t6_re_done", done_a, 0);
    check("t6_re_rdy", rdy_a, 1);
    put(32'h0, 0);
    @(negedge clk);
    check("t6_re_fin", done_a, 1); check("t6_re_wi", wi_a, 0);

    repeat (3) @(negedge clk);
    check("qa_empty", qa.size(), 0);
    check("qb_empty", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
